gpu_cmd_queue: RTL and testbench

Command queue and sequencer that sits directly upstream of the GPU draw/clear engine. It accepts draw and clear commands from the CPU bus bridge through a valid/ready port and buffers them in a synchronous FIFO. It replays each command to the GPU control port with the setup/strobe/busy protocol the GPU requires, so software can enqueue a batch without polling the GPU busy flag.

---
 rtl/gpu_pkg.sv | 43 ++++
 rtl/gpu_cmd_fifo.sv | 55 +++++
 rtl/gpu_cmd_queue.sv | 150 +++++++++++++++
 tb/tb_gpu_cmd_queue.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command path: op codes, sequencer states and the
// packed command-record layout (LSB first) used by the queue and the bus bridge.
package gpu_pkg;

    localparam logic OP_DRAW  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FIRE  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam int OFF_OP     = 0;
    localparam int OFF_ADDR   = 1;
    localparam int OFF_ADDR_X = 33;
    localparam int OFF_ADDR_Y = 49;
    localparam int OFF_IMG_W  = 65;
    localparam int OFF_WIDTH  = 81;

    // Offsets past OFF_WIDTH depend on the framebuffer-derived widths w and h.
    function automatic int off_x(input int w);
        return OFF_WIDTH + w;
    endfunction

    function automatic int off_height(input int w);
        return OFF_WIDTH + 2 * w;
    endfunction

    function automatic int off_y(input int w, input int h);
        return OFF_WIDTH + 2 * w + h;
    endfunction

    function automatic int off_clear_color(input int w, input int h);
        return OFF_WIDTH + 2 * w + 2 * h;
    endfunction

    function automatic int rec_width(input int w, input int h);
        return OFF_WIDTH + 2 * w + 2 * h + 16;
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO, DEPTH entries (power of two), head presented combinationally.
// Push is dropped when full and pop when empty; simultaneous push and pop both complete.
module gpu_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/gpu_cmd_queue.sv
// Buffers draw/clear commands and replays each to the GPU as setup/strobe/wait; GPU_CMDQ_STATS_EN builds the counters.
// Strobe 3 cycles after a push into an idle queue, min 4 cycles between strobes; cmd_ready = FIFO not full.
module gpu_cmd_queue
    import gpu_pkg::*;
#(
    parameter  int FB_WIDTH  = 400,
    parameter  int FB_HEIGHT = 240,
    parameter  int DEPTH     = 8,
    localparam int W         = $clog2(FB_WIDTH) + 2,
    localparam int H         = $clog2(FB_HEIGHT) + 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic [31:0]            cmd_address,
    input  logic [15:0]            cmd_address_x,
    input  logic [15:0]            cmd_address_y,
    input  logic [15:0]            cmd_image_width,
    input  logic [W-1:0]           cmd_width,
    input  logic [W-1:0]           cmd_x,
    input  logic [H-1:0]           cmd_height,
    input  logic [H-1:0]           cmd_y,
    input  logic [15:0]            cmd_clear_color,
    output logic [$clog2(DEPTH):0] q_level,
    output logic                   q_idle,
    output logic [31:0]            ctrl_address,
    output logic [15:0]            ctrl_address_x,
    output logic [15:0]            ctrl_address_y,
    output logic [15:0]            ctrl_image_width,
    output logic [W-1:0]           ctrl_width,
    output logic [W-1:0]           ctrl_x,
    output logic [H-1:0]           ctrl_height,
    output logic [H-1:0]           ctrl_y,
    output logic [15:0]            ctrl_clear_color,
    output logic                   ctrl_draw,
    output logic                   ctrl_clear,
    input  logic                   gpu_busy,
    output logic [31:0]            stat_cmds,
    output logic [31:0]            stat_stalls
);

    localparam int RW    = rec_width(W, H);
    localparam int O_X   = off_x(W);
    localparam int O_HGT = off_height(W);
    localparam int O_Y   = off_y(W, H);
    localparam int O_CC  = off_clear_color(W, H);

    logic [RW-1:0] push_rec;
    logic [RW-1:0] head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          fire_next;
    logic          ctrl_op;
    state_t        state;
    state_t        next_state;

    assign push_rec = {cmd_clear_color, cmd_y, cmd_height, cmd_x, cmd_width,
                       cmd_image_width, cmd_address_y, cmd_address_x, cmd_address, cmd_op};

    gpu_cmd_fifo #(.DEPTH(DEPTH), .DW(RW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .wdata (push_rec),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (q_level)
    );

    assign cmd_ready = !full;
    assign q_idle    = empty && (state == ST_IDLE) && !gpu_busy;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (!empty)   next_state = ST_SETUP;
            ST_SETUP: if (!gpu_busy) next_state = ST_FIRE;
            ST_FIRE:                next_state = ST_WAIT;
            ST_WAIT:  if (!gpu_busy) next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == ST_IDLE) && !empty;
        fire_next = (state == ST_SETUP) && !gpu_busy;
    end

    // A CLEAR only touches the colour, so draw fields from the previous DRAW persist.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_op          <= OP_DRAW;
            ctrl_address     <= '0;
            ctrl_address_x   <= '0;
            ctrl_address_y   <= '0;
            ctrl_image_width <= '0;
            ctrl_width       <= '0;
            ctrl_x           <= '0;
            ctrl_height      <= '0;
            ctrl_y           <= '0;
            ctrl_clear_color <= '0;
            ctrl_draw        <= 1'b0;
            ctrl_clear       <= 1'b0;
        end else begin
            ctrl_draw  <= fire_next && (ctrl_op == OP_DRAW);
            ctrl_clear <= fire_next && (ctrl_op == OP_CLEAR);
            if (pop) begin
                ctrl_op <= head[OFF_OP];
                if (head[OFF_OP] == OP_DRAW) begin
                    ctrl_address     <= head[OFF_ADDR +: 32];
                    ctrl_address_x   <= head[OFF_ADDR_X +: 16];
                    ctrl_address_y   <= head[OFF_ADDR_Y +: 16];
                    ctrl_image_width <= head[OFF_IMG_W +: 16];
                    ctrl_width       <= head[OFF_WIDTH +: W];
                    ctrl_x           <= head[O_X +: W];
                    ctrl_height      <= head[O_HGT +: H];
                    ctrl_y           <= head[O_Y +: H];
                end else begin
                    ctrl_clear_color <= head[O_CC +: 16];
                end
            end
        end
    end

`ifdef GPU_CMDQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cmds   <= '0;
            stat_stalls <= '0;
        end else begin
            if (state == ST_FIRE)        stat_cmds   <= stat_cmds + 1'b1;
            if (cmd_valid && !cmd_ready) stat_stalls <= stat_stalls + 1'b1;
        end
    end
`else
    assign stat_cmds   = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Directed bench for gpu_cmd_queue: a scoreboard of expected strobes is filled on acceptance
// and drained by a monitor that compares every observed GPU strobe.
module tb_gpu_cmd_queue;

    localparam int W = 11;
    localparam int H = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [31:0]   cmd_address;
    logic [15:0]   cmd_address_x, cmd_address_y, cmd_image_width;
    logic [W-1:0]  cmd_width, cmd_x;
    logic [H-1:0]  cmd_height, cmd_y;
    logic [15:0]   cmd_clear_color;
    logic [3:0]    q_level;
    logic          q_idle;
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x, ctrl_address_y, ctrl_image_width;
    logic [W-1:0]  ctrl_width, ctrl_x;
    logic [H-1:0]  ctrl_height, ctrl_y;
    logic [15:0]   ctrl_clear_color;
    logic          ctrl_draw, ctrl_clear;
    logic          gpu_busy;
    logic [31:0]   stat_cmds, stat_stalls;

    always #5 clk = ~clk;

    gpu_cmd_queue dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_address(cmd_address), .cmd_address_x(cmd_address_x), .cmd_address_y(cmd_address_y),
        .cmd_image_width(cmd_image_width), .cmd_width(cmd_width), .cmd_x(cmd_x),
        .cmd_height(cmd_height), .cmd_y(cmd_y), .cmd_clear_color(cmd_clear_color),
        .q_level(q_level), .q_idle(q_idle),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x), .ctrl_address_y(ctrl_address_y),
        .ctrl_image_width(ctrl_image_width), .ctrl_width(ctrl_width), .ctrl_x(ctrl_x),
        .ctrl_height(ctrl_height), .ctrl_y(ctrl_y), .ctrl_clear_color(ctrl_clear_color),
        .ctrl_draw(ctrl_draw), .ctrl_clear(ctrl_clear), .gpu_busy(gpu_busy),
        .stat_cmds(stat_cmds), .stat_stalls(stat_stalls)
    );

    // GPU model: busy from the strobe cycle for busy_len cycles, plus an external hold.
    int   busy_len = 128;
    logic hold_busy = 1'b0;
    int   bcnt = 0;
    int   cyc = 0;
    assign gpu_busy = hold_busy || (bcnt != 0) || ctrl_draw || ctrl_clear;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset)                        bcnt <= 0;
        else if (ctrl_draw || ctrl_clear) bcnt <= busy_len - 1;
        else if (bcnt != 0)               bcnt <= bcnt - 1;
    end

    typedef struct packed {
        logic         op;
        logic [31:0]  a;
        logic [15:0]  ax, ay, iw;
        logic [W-1:0] w, x;
        logic [H-1:0] h, y;
        logic [15:0]  cc;
    } rec_t;

    typedef struct {
        int   cyc;
        rec_t r;
    } exp_t;

    exp_t sb[$];
    rec_t model = '0;
    int   vectors = 0;
    int   miscompares = 0;
    int   strobe_cnt = 0;
    int   last_strobe = -1;
`ifdef GPU_CMDQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rec_t mk(input logic op, input logic [31:0] a, input logic [15:0] iw,
                                input int w, input int x, input int h, input int y, input logic [15:0] cc);
        rec_t r;
        r = '0;
        r.op = op; r.a = a; r.iw = iw; r.cc = cc;
        r.w = W'(w); r.x = W'(x); r.h = H'(h); r.y = H'(y);
        return r;
    endfunction

    always @(negedge clk) begin
        rec_t obs;
        exp_t e;
        if (!reset && (ctrl_draw || ctrl_clear)) begin
            strobe_cnt++;
            last_strobe = cyc;
            obs = {ctrl_clear, ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
                   ctrl_width, ctrl_x, ctrl_height, ctrl_y, ctrl_clear_color};
            check("single_strobe", ctrl_draw && ctrl_clear, 0);
            check("strobe_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("strobe_record", obs, e.r);
                if (e.cyc >= 0) check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 of the cycle after acceptance with cmd_valid still high.
    task automatic offer(input rec_t r, input int off, output int acc);
        int   n = 0;
        exp_t e;
        cmd_op = r.op; cmd_address = r.a; cmd_address_x = r.ax; cmd_address_y = r.ay;
        cmd_image_width = r.iw; cmd_width = r.w; cmd_x = r.x; cmd_height = r.h; cmd_y = r.y;
        cmd_clear_color = r.cc;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("offer_accept", cmd_ready, 1);
        acc = cyc;
        if (cmd_ready) begin
            if (r.op == 1'b0) model = {r.op, r.a, r.ax, r.ay, r.iw, r.w, r.x, r.h, r.y, model.cc};
            else begin model.op = r.op; model.cc = r.cc; end
            e.cyc = (off >= 0) ? acc + off : -1;
            e.r   = model;
            sb.push_back(e);
        end
        @(posedge clk); #2;
    endtask

    task automatic wait_idle(input string name, input int budget, output int at);
        int n = 0;
        @(negedge clk);
        while (!q_idle && n < budget) begin
            n++;
            @(negedge clk);
        end
        check(name, q_idle, 1);
        at = cyc;
        @(posedge clk); #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, acc, at, sc0, r, n;
        rec_t rr;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_address = '0;
        cmd_address_x = '0; cmd_address_y = '0; cmd_image_width = '0; cmd_width = '0;
        cmd_x = '0; cmd_height = '0; cmd_y = '0; cmd_clear_color = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_fields", {ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
                             ctrl_width, ctrl_x, ctrl_height, ctrl_y, ctrl_clear_color}, 0);
        check("rst_strobes", {ctrl_draw, ctrl_clear}, 0);
        check("rst_level", q_level, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_idle", q_idle, 1);
        check("rst_stats", {stat_cmds, stat_stalls}, 0);
        @(posedge clk); #2;

        // Single DRAW, busy 128 cycles
        c = cyc;
        offer(mk(1'b0, 32'h1000, 16'd400, 16, 10, 8, 20, 16'h0), 3, acc);
        cmd_valid = 1'b0;
        check("t1_accept_cycle", acc, c);
        while (cyc < c + 2) @(negedge clk);
        check("t1_setup_fields", {ctrl_address, ctrl_width, ctrl_height, ctrl_x, ctrl_y},
              {32'h1000, 11'd16, 10'd8, 11'd10, 10'd20});
        check("t1_setup_no_strobe", ctrl_draw, 0);
        check("t1_setup_level", q_level, 0);
        wait_idle("t1_idle", 300, at);
        check("t1_idle_cycle", at, c + 132);

        // CLEAR then DRAW: colour-only load, 4-cycle gap after busy ends
        busy_len = 16;
        c = cyc;
        offer(mk(1'b1, 32'hDEAD, 16'd7, 5, 5, 5, 5, 16'hF801), 3, acc);
        offer(mk(1'b0, 32'h2000, 16'd400, 32, 100, 16, 50, 16'h1234), 21, acc);
        cmd_valid = 1'b0;
        check("t2_draw_accept", acc, c + 1);
        wait_idle("t2_idle", 200, at);
        check("t2_color_kept", ctrl_clear_color, 16'hF801);

        // Fill with GPU held busy; 10th command must stall
        busy_len = 4;
        hold_busy = 1'b1;
        sc0 = strobe_cnt;
        c = cyc;
        for (int i = 0; i < 9; i++) begin
            rr = mk(i[0], 32'h3000 + 32'(i) * 32'h100, 16'd320, i + 1, i, i + 2, i * 3, 16'h0100 + 16'(i));
            offer(rr, -1, acc);
            check("t3_b2b_accept", acc - c, i);
        end
        cmd_op = 1'b0; cmd_address = 32'hBAD0;
        @(negedge clk);
        check("t3_full_ready", cmd_ready, 0);
        check("t3_full_level", q_level, 8);
        repeat (11) @(negedge clk);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t3_no_strobe_held", strobe_cnt, sc0);
        check("t3_stalls", stat_stalls, STATS ? 12 : 0);
        hold_busy = 1'b0;
        wait_idle("t3_idle", 300, at);
        check("t3_all_issued", strobe_cnt, sc0 + 9);
        check("t3_cmds", stat_cmds, STATS ? 12 : 0);
        check("t3_stalls_final", stat_stalls, STATS ? 12 : 0);

        // Busy before the first push: SETUP holds, strobe one cycle after release
        hold_busy = 1'b1;
        sc0 = strobe_cnt;
        offer(mk(1'b0, 32'h4000, 16'd64, 8, 1, 4, 2, 16'h0), -1, acc);
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("t4_held_no_strobe", strobe_cnt, sc0);
        check("t4_held_fields", ctrl_address, 32'h4000);
        check("t4_held_level", q_level, 0);
        hold_busy = 1'b0;
        r = cyc;
        n = 0;
        while (strobe_cnt == sc0 && n < 20) begin n++; @(negedge clk); end
        check("t4_strobe_seen", strobe_cnt, sc0 + 1);
        check("t4_strobe_cycle", last_strobe, r + 1);
        @(posedge clk); #2;
        wait_idle("t4_idle", 300, at);

        // Reset during WAIT with three entries queued
        busy_len = 40;
        c = cyc;
        offer(mk(1'b0, 32'h5000, 16'd1, 1, 1, 1, 1, 16'h0), 3, acc);
        offer(mk(1'b1, 32'h0, 16'd0, 0, 0, 0, 0, 16'h07E0), -1, acc);
        offer(mk(1'b0, 32'h6000, 16'd2, 2, 2, 2, 2, 16'h0), -1, acc);
        offer(mk(1'b0, 32'h7000, 16'd3, 3, 3, 3, 3, 16'h0), -1, acc);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t5_level_before", q_level, 3);
        check("t5_busy_in_wait", q_idle, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        sb.delete();
        model = '0;
        @(posedge clk); #2;
        reset = 1'b0;
        sc0 = strobe_cnt;
        @(negedge clk);
        check("t5_rst_level", q_level, 0);
        check("t5_rst_strobes", {ctrl_draw, ctrl_clear}, 0);
        check("t5_rst_idle", q_idle, 1);
        check("t5_rst_fields", {ctrl_address, ctrl_clear_color}, 0);
        check("t5_rst_stats", {stat_cmds, stat_stalls}, 0);
        repeat (30) @(negedge clk);
        check("t5_no_replay", strobe_cnt, sc0);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
